// File: rtl/sap_core_p.sv
// ============================================================================
// sap_core_p : parametrised single-bus accumulator CPU with internal RAM
// Rev 1.0
// ============================================================================
`default_nettype none

module sap_core_p #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic [DW-1:0] DataOut,
  output logic          out_valid,
  output logic          halted,
  output logic          carry,
  output logic          zero
);

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JC  = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_T1   = 3'd0,
    S_T2   = 3'd1,
    S_T3   = 3'd2,
    S_T4   = 3'd3,
    S_T5   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  if (DW < AW + 4) begin : g_bad_params
    $error("sap_core_p: DW must be at least AW+4");
  end

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] mar_q;
  logic [DW-1:0] ir_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] dout_q;
  logic          carry_q;
  logic          zero_q;
  logic          out_valid_q;
  logic          halted_q;
  logic [DW-1:0] mem_q [0:(1<<AW)-1];

  logic [DW-1:0] ram_rd;
  logic [3:0]    opcode;
  logic [AW-1:0] addr_f;
  logic [DW-1:0] imm;
  logic [AW-1:0] pc_d;
  logic          take_d;
  logic          is_sub;
  logic [DW:0]   alu_b;
  logic [DW:0]   alu_sum;

  always_comb begin
    ram_rd  = mem_q[mar_q];
    opcode  = ir_q[DW-1:DW-4];
    addr_f  = ir_q[AW-1:0];
    imm     = {4'b0000, ir_q[DW-5:0]};
    pc_d    = pc_q + AW'(1);
    take_d  = (opcode == OP_JMP) ||
              ((opcode == OP_JC) && carry_q) ||
              ((opcode == OP_JZ) && zero_q);
    // SUB is A + ~B + 1; the carry-out is then the "no borrow" flag.
    is_sub  = (opcode == OP_SUB);
    alu_b   = is_sub ? {1'b0, ~b_q} : {1'b0, b_q};
    alu_sum = {1'b0, a_q} + alu_b + {{DW{1'b0}}, is_sub};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_T1;
      pc_q        <= '0;
      mar_q       <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      dout_q      <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      if (prog_we) begin
        mem_q[prog_addr] <= prog_data;
      end
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        S_T1: begin
          mar_q   <= pc_q;
          state_q <= S_T2;
        end
        S_T2: begin
          ir_q    <= ram_rd;
          pc_q    <= pc_d;
          state_q <= S_T3;
        end
        S_T3: begin
          state_q <= S_T1;
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              mar_q   <= addr_f;
              state_q <= S_T4;
            end
            OP_LDI: a_q <= imm;
            OP_JMP, OP_JC, OP_JZ: begin
              if (take_d) begin
                pc_q <= addr_f;
              end
            end
            OP_OUT: begin
              dout_q      <= a_q;
              out_valid_q <= 1'b1;
            end
            OP_HLT: begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end
            default: ;
          endcase
        end
        S_T4: begin
          state_q <= S_T1;
          case (opcode)
            OP_LDA: a_q <= ram_rd;
            OP_ADD, OP_SUB: begin
              b_q     <= ram_rd;
              state_q <= S_T5;
            end
            OP_STA: mem_q[mar_q] <= a_q;
            default: ;
          endcase
        end
        S_T5: begin
          a_q     <= alu_sum[DW-1:0];
          carry_q <= alu_sum[DW];
          zero_q  <= (alu_sum[DW-1:0] == '0);
          state_q <= S_T1;
        end
        S_HALT: begin
          if (prog_we) begin
            mem_q[prog_addr] <= prog_data;
          end
        end
        default: state_q <= S_T1;
      endcase
    end
  end

  assign DataOut   = dout_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

endmodule

`default_nettype wire

// File: doc/sap_core_p.md
Name: sap_core_p

Overview:
- Parametrised successor to the SAP-1 top level: a single-bus accumulator CPU with internal program/data RAM.
- Generalised in data width and address depth; adds carry/zero flags, STA, LDI, conditional/unconditional jumps, an explicit HALT state and a program-load port.
- Sits at the top of the SAP hierarchy; the testbench loads RAM during reset and observes DataOut.

Parameters:
- DW, 8: data and instruction word width; must be ≥ AW+4.
- AW, 4: RAM address width; RAM depth = 2^AW words and PC width = AW.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  synchronous active-high reset.
- prog_we  input  1  RAM program write strobe; honoured only while clr=1 or halted=1.
- prog_addr  input  AW  RAM program write address.
- prog_data  input  DW  RAM program write data.
- DataOut  output  DW  output register; written by OUT.
- out_valid  output  1  one-cycle pulse in the cycle after DataOut is updated.
- halted  output  1  high while in the HALT state.
- carry  output  1  carry flag.
- zero  output  1  zero flag.

Behaviour:
- Instruction format: opcode = instr[DW-1:DW-4]; address field = instr[AW-1:0]; immediate = instr[DW-5:0], zero-extended to DW.
- Opcodes:
  - 0 LDA: A<=RAM[a]
  - 1 ADD: B<=RAM[a], then A<=A+B
  - 2 SUB: B<=RAM[a], then A<=A-B
  - 3 STA: RAM[a]<=A
  - 4 LDI: A<=imm
  - 5 JMP: PC<=a
  - 6 JC: jump if carry=1
  - 7 JZ: jump if zero=1
  - 8-D: NOP
  - E OUT: DataOut<=A
  - F HLT
- Reset (clr=1, every edge): PC, MAR, IR, A, B, DataOut = 0; carry, zero, out_valid, halted = 0; state = T1.
  - RAM is not cleared; prog_we writes RAM[prog_addr]<=prog_data on the same edge.
- State machine, one state per clock:
  - T1: MAR<=PC.
  - T2: IR<=RAM[MAR]; PC<=PC+1 (mod 2^AW).
  - T3: decode and execute.
    - LDA/ADD/SUB/STA: MAR<=a, go to T4.
    - LDI, JMP, taken JC/JZ, untaken JC/JZ, NOP, OUT: complete here, go to T1.
    - HLT: go to HALT.
  - T4: LDA/ADD/SUB: A or B loaded from RAM[MAR].
    - LDA goes to T1.
    - ADD/SUB load B here and go to T5.
    - STA writes RAM and goes to T1.
  - T5 (ADD/SUB only): A<=result; flags updated; go to T1.
- Cycle counts:
  - LDA, STA: 4 cycles.
  - ADD, SUB: 5 cycles.
  - All other instructions: 3 cycles.
- Arithmetic and flags:
  - ADD: {carry,A}<=A+B; zero<=(A+B mod 2^DW)==0.
  - SUB: A<=A+~B+1 mod 2^DW; carry<=1 iff A≥B (no borrow); zero<=(result==0).
  - No other instruction modifies the flags.
- RAM: synchronous write; read is combinational from MAR, sampled at T2/T4. A taken jump to the current PC value is legal.
- OUT: DataOut<=A at T3; out_valid=1 during the following cycle only.
- HALT: holds all registers and outputs; halted=1. Leaves HALT only via clr. prog_we is honoured in HALT. CPU writes via STA never collide with program writes.
- prog_we while running (clr=0, halted=0) is ignored.
- Wrap-around: PC increments from 2^AW-1 to 0; execution continues.
- clr asserted mid-instruction aborts it on that edge; any STA not yet at T4 has no effect.

Test Plan:
- DW=8, AW=4; load {0x0E:0x07, 0x0F:0x05}; program `LDA E; ADD F; OUT; HLT` (0x0E,0x1F,0xE0,0xF0); release clr → DataOut=0x0C, out_valid pulses once, carry=0, zero=0, halted=1 exactly 3+4+5+3 cycles after clr release.
- SUB borrow: A=0x03, B=0x05 → A=0xFE, carry=0, zero=0; then A=0x05 SUB 0x05 → A=0x00, carry=1, zero=1.
- ADD overflow: 0xFF+0x01 → A=0x00, carry=1, zero=1; following `JC 7` jumps to addr 7; `JZ` with zero=0 falls through to PC+1 in 3 cycles.
- `LDI 0xA; STA D; LDA D; OUT; HLT` → RAM[0xD]=0x0A, DataOut=0x0A; RAM[0xD] retains 0x0A after a subsequent clr.
- PC wrap: NOP at addr 0xF, OUT at 0x0 → after executing 0xF, PC=0 and OUT is re-executed; prog_we pulsed while running leaves RAM unchanged.
- Assert clr during T4 of an ADD → all outputs 0 on the next edge; after release, execution restarts at addr 0 and the result is identical to an uninterrupted run.
